// File: rtl/jk_q_monitor_if.sv
// Signal bundle between a JK flip-flop Q source and its activity monitor.
// The source drives q/clr. The monitor answers with registered status.
interface jk_q_monitor_if #(
  parameter int CNT_W = 8
);
  logic             q;
  logic             clr;
  logic             level;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] toggles;
  logic [CNT_W-1:0] run_len;
  logic             stuck;
  logic [1:0]       state;

  // Handshake: there is no valid/ready. q and clr are sampled on every rising
  // edge of clk. Every status signal is a register that updates on that edge.
  modport master (
    output q, clr,
    input  level, rise, fall, toggles, run_len, stuck, state
  );

  modport slave (
    input  q, clr,
    output level, rise, fall, toggles, run_len, stuck, state
  );
endinterface

// File: rtl/jk_q_monitor.sv
// Watches the Q output of a JK flip-flop. It reports edges, counts toggles and
// run length, and flags a Q that has not moved for STUCK_LIMIT cycles.
module jk_q_monitor #(
  parameter int CNT_W       = 8,
  parameter int STUCK_LIMIT = 16
) (
  input  logic         clk,
  input  logic         rst,
  jk_q_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10,
    ST_STUCK = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LIMIT_VAL = CNT_W'(STUCK_LIMIT);

  state_t           r_state;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic [CNT_W-1:0] r_toggles;
  logic [CNT_W-1:0] r_run_len;
  logic             r_stuck;

  state_t           w_state_nxt;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic [CNT_W-1:0] w_toggles_nxt;
  logic [CNT_W-1:0] w_run_len_nxt;
  logic             w_change;
  logic [CNT_W-1:0] w_toggles_inc;
  logic [CNT_W-1:0] w_run_len_inc;

  always_comb begin
    w_change      = (mon.q != r_level);
    w_toggles_inc = (r_toggles == CNT_MAX) ? r_toggles : r_toggles + CNT_ONE;
    w_run_len_inc = (r_run_len == CNT_MAX) ? r_run_len : r_run_len + CNT_ONE;

    w_state_nxt   = r_state;
    w_level_nxt   = mon.q;
    w_rise_nxt    = 1'b0;
    w_fall_nxt    = 1'b0;
    w_toggles_nxt = r_toggles;
    w_run_len_nxt = r_run_len;

    case (r_state)
      // The first edge only loads level. There is no previous value to compare against.
      ST_INIT: begin
        w_state_nxt = mon.q ? ST_HIGH : ST_LOW;
      end
      default: begin
        if (w_change) begin
          // A change beats clr. The clear applies first, so this edge counts as toggle 1.
          w_state_nxt   = mon.q ? ST_HIGH : ST_LOW;
          w_rise_nxt    = mon.q;
          w_fall_nxt    = ~mon.q;
          w_toggles_nxt = mon.clr ? CNT_ONE : w_toggles_inc;
          w_run_len_nxt = '0;
        end else if (mon.clr) begin
          w_toggles_nxt = '0;
          w_run_len_nxt = '0;
        end else begin
          w_run_len_nxt = w_run_len_inc;
          if (r_state != ST_STUCK && w_run_len_inc == LIMIT_VAL) begin
            w_state_nxt = ST_STUCK;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_level   <= 1'b0;
      r_rise    <= 1'b0;
      r_fall    <= 1'b0;
      r_toggles <= '0;
      r_run_len <= '0;
      r_stuck   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_level   <= w_level_nxt;
      r_rise    <= w_rise_nxt;
      r_fall    <= w_fall_nxt;
      r_toggles <= w_toggles_nxt;
      r_run_len <= w_run_len_nxt;
      r_stuck   <= (w_state_nxt == ST_STUCK);
    end
  end

  assign mon.level   = r_level;
  assign mon.rise    = r_rise;
  assign mon.fall    = r_fall;
  assign mon.toggles = r_toggles;
  assign mon.run_len = r_run_len;
  assign mon.stuck   = r_stuck;
  assign mon.state   = r_state;

endmodule

// File: doc/jk_q_monitor.md
JK_Q_MONITOR -- requirements
Module: jk_q_monitor

Interface
REQ-001 Parameter: CNT_W, default 8, width of the toggle and run-length counters.
REQ-002 Parameter: STUCK_LIMIT, default 16, number of cycles without a q change that counts as stuck (legal range 2..2^CNT_W-1).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 q  input  1  Q output of the upstream JK flip-flop, synchronous to clk.
REQ-006 clr  input  1  synchronous clear of toggles and run_len; state is kept.
REQ-007 level  output  1  registered copy of q.
REQ-008 rise  output  1  one-cycle pulse for a 0->1 change of q.
REQ-009 fall  output  1  one-cycle pulse for a 1->0 change of q.
REQ-010 toggles  output  CNT_W  saturating count of detected changes.
REQ-011 run_len  output  CNT_W  saturating count of cycles since the last change.
REQ-012 stuck  output  1  high while the monitor is in state STUCK.
REQ-013 state  output  2  FSM encoding: INIT=00, LOW=01, HIGH=10, STUCK=11.

Function
REQ-014 Sampling: every rising edge, level <= q; a change means q != level at that edge.
REQ-015 FSM INIT: the first edge after reset loads level and moves to LOW (q=0) or HIGH (q=1); no pulse, no count.
REQ-016 FSM LOW -> HIGH on a change; HIGH -> LOW on a change; rise or fall, respectively, is asserted for exactly the following cycle.
REQ-017 Edge latency: q changes before edge N; edge N registers rise/fall, toggles+1 and run_len=0; all are visible during cycle N..N+1 and rise/fall clear at edge N+1 unless another change occurs.
REQ-018 run_len: increments by 1 each edge with no change; cleared to 0 on a change; saturates at 2^CNT_W-1.
REQ-019 STUCK entry: from LOW or HIGH, the edge at which run_len becomes STUCK_LIMIT moves to STUCK; stuck=1 from that cycle.
REQ-020 STUCK exit: a change goes to HIGH (q=1) or LOW (q=0) with the normal pulse, count and run_len=0; stuck=0 the same cycle.
REQ-021 toggles: saturates at 2^CNT_W-1; further changes still pulse rise/fall.
REQ-022 Alternating q every cycle: rise and fall alternate on consecutive cycles; they are never both high.
REQ-023 clr: at that edge toggles=0 and run_len=0, and FSM stays in its current state; if the state is STUCK, it stays STUCK until a change occurs.
REQ-024 clr and a simultaneous change: the change wins for pulses and state; toggles=1 and run_len=0.
REQ-025 All outputs are registered, with no combinational path from q or clr to any output.

Reset
REQ-026 rst high at an edge: state=INIT, level=0, rise=0, fall=0, toggles=0, run_len=0, stuck=0.
REQ-027 rst takes priority over clr and q changes; asserting rst mid-run discards all counts and pulses at that edge.
REQ-028 The first edge with rst low behaves as INIT per REQ-015.

Verification
REQ-029 Reset, then q held 0 for 5 cycles -> state INIT->LOW, rise=fall=0, toggles=0, run_len=4 after the 5th edge.
REQ-030 Drive q 0,1,0,1 on consecutive edges after LOW -> rise, fall, rise pulses on successive cycles; toggles=3; run_len=0.
REQ-031 q held 1 for STUCK_LIMIT=16 edges from HIGH -> stuck=1 and state=11 exactly at the 16th edge; q->0 -> fall=1, stuck=0, state=LOW.
REQ-032 CNT_W=4: 20 toggles -> toggles holds 15, pulses continue; run_len saturates at 15 when idle.
REQ-033 clr together with a q change (toggles=7 before) -> toggles=1, run_len=0, correct pulse; clr alone in STUCK -> counts 0, stuck stays 1.
REQ-034 rst asserted while rise=1 and toggles=9 -> next cycle all outputs at reset values, state INIT.
